xadac_axi_wr_arb: RTL and testbench

- Shares one downstream single-beat AXI write port (AW/W/B) between NumReq xadac store units, e.g. activation store and a second vector store unit.
- AW is arbitrated round-robin. W beats are forwarded strictly in AW-grant order through an order FIFO.
- B responses are routed back by a requester index prepended to the downstream ID.
- Sits between the xadac accelerator units and the system AXI crossbar port.

---
 rtl/xadac_axi_wr_arb.sv | 114 +++++++++++
 tb/tb_xadac_axi_wr_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xadac_axi_wr_arb.sv
// xadac_axi_wr_arb: round-robin share of one single-beat AXI write port; W follows AW grant order, B routed by ID prefix.
module xadac_axi_wr_arb #(
  parameter int NumReq    = 2,
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 128,
  parameter int OrdDepth  = 4,
  parameter int IdxWidth  = $clog2(NumReq)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NumReq-1:0][IdWidth-1:0]        req_aw_id,
  input  logic [NumReq-1:0][AddrWidth-1:0]      req_aw_addr,
  input  logic [NumReq-1:0]                     req_aw_valid,
  output logic [NumReq-1:0]                     req_aw_ready,
  input  logic [NumReq-1:0][DataWidth-1:0]      req_w_data,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    req_w_strb,
  input  logic [NumReq-1:0]                     req_w_valid,
  output logic [NumReq-1:0]                     req_w_ready,
  output logic [NumReq-1:0][IdWidth-1:0]        req_b_id,
  output logic [NumReq-1:0]                     req_b_valid,
  input  logic [NumReq-1:0]                     req_b_ready,
  output logic [IdxWidth+IdWidth-1:0]           axi_aw_id,
  output logic [AddrWidth-1:0]                  axi_aw_addr,
  output logic                                  axi_aw_valid,
  input  logic                                  axi_aw_ready,
  output logic [DataWidth-1:0]                  axi_w_data,
  output logic [DataWidth/8-1:0]                axi_w_strb,
  output logic                                  axi_w_valid,
  input  logic                                  axi_w_ready,
  input  logic [IdxWidth+IdWidth-1:0]           axi_b_id,
  input  logic                                  axi_b_valid,
  output logic                                  axi_b_ready
);
  localparam int PtrWidth = $clog2(OrdDepth);
  logic                          aw_valid_q, w_valid_q;
  logic [IdxWidth+IdWidth-1:0]   aw_id_q;
  logic [AddrWidth-1:0]          aw_addr_q;
  logic [DataWidth-1:0]          w_data_q;
  logic [DataWidth/8-1:0]        w_strb_q;
  logic [OrdDepth-1:0][IdxWidth-1:0] ord_q;
  logic [PtrWidth-1:0]           rd_q, wr_q;
  logic [PtrWidth:0]             cnt_q;
  logic [IdxWidth-1:0]           rr_q, gnt_idx, cand, head, b_idx;
  logic                          gnt, fwd, aw_free, w_free, full, empty, b_ok;
  assign aw_free = !aw_valid_q || axi_aw_ready;
  assign w_free  = !w_valid_q || axi_w_ready;
  assign full    = cnt_q == (PtrWidth+1)'(OrdDepth);
  assign empty   = cnt_q == '0;
  assign head    = ord_q[rd_q];
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxWidth'((int'(rr_q) + i) % NumReq);
      if (!gnt && req_aw_valid[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt && aw_free && !full && !rst;
  end
  // W may only leave for the requester whose AW sits at the order-FIFO head
  assign fwd          = w_free && !empty && req_w_valid[head] && !rst;
  assign req_aw_ready = NumReq'(gnt) << gnt_idx;
  assign req_w_ready  = NumReq'(fwd) << head;
  assign axi_aw_id    = aw_id_q;
  assign axi_aw_addr  = aw_addr_q;
  assign axi_aw_valid = aw_valid_q;
  assign axi_w_data   = w_data_q;
  assign axi_w_strb   = w_strb_q;
  assign axi_w_valid  = w_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_valid_q <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
    end else begin
      if (aw_free) aw_valid_q <= gnt;
      if (gnt) begin
        aw_id_q   <= {gnt_idx, req_aw_id[gnt_idx]};
        aw_addr_q <= req_aw_addr[gnt_idx];
        wr_q      <= wr_q + 1'b1;
        rr_q      <= IdxWidth'((int'(gnt_idx) + 1) % NumReq);
      end
      if (w_free) w_valid_q <= fwd;
      if (fwd) begin
        w_data_q <= req_w_data[head];
        w_strb_q <= req_w_strb[head];
        rd_q     <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + (PtrWidth+1)'(gnt) - (PtrWidth+1)'(fwd);
    end
  end
  always_ff @(posedge clk) begin
    if (gnt) ord_q[wr_q] <= gnt_idx;
  end
  assign b_idx       = axi_b_id[IdxWidth+IdWidth-1 -: IdxWidth];
  assign b_ok        = int'(b_idx) < NumReq;
  assign req_b_valid = NumReq'(axi_b_valid && b_ok) << b_idx;
  assign req_b_id    = {NumReq{axi_b_id[IdWidth-1:0]}};
  // responses tagged with a nonexistent requester are swallowed
  assign axi_b_ready = !b_ok || req_b_ready[b_idx];
  a_b_idx: assert property (@(posedge clk) disable iff (rst) axi_b_valid |-> b_ok)
    else $error("B response with requester index out of range");
endmodule

// File: tb/tb_xadac_axi_wr_arb.sv
// tb_xadac_axi_wr_arb: directed stimulus with a queue-based reference model checked every cycle.
module tb_xadac_axi_wr_arb;
  typedef struct { logic [3:0] id; logic [31:0] addr; } aw_t;
  typedef struct { logic [127:0] d; logic [15:0] s; } w_t;
  logic clk = 1'b0, rst;
  logic [1:0][3:0]   req_aw_id;
  logic [1:0][31:0]  req_aw_addr;
  logic [1:0]        req_aw_valid, req_aw_ready;
  logic [1:0][127:0] req_w_data;
  logic [1:0][15:0]  req_w_strb;
  logic [1:0]        req_w_valid, req_w_ready;
  logic [1:0][3:0]   req_b_id;
  logic [1:0]        req_b_valid, req_b_ready;
  logic [4:0]        axi_aw_id, axi_b_id;
  logic [31:0]       axi_aw_addr;
  logic              axi_aw_valid, axi_aw_ready;
  logic [127:0]      axi_w_data;
  logic [15:0]       axi_w_strb;
  logic              axi_w_valid, axi_w_ready, axi_b_valid, axi_b_ready;
  int tests = 0, fails = 0;
  aw_t awq[2][$];
  w_t  wq[2][$];
  int  awlog[$];
  logic [127:0] wlog[$];
  always #5 clk = ~clk;
  xadac_axi_wr_arb dut (
    .clk(clk), .rst(rst),
    .req_aw_id(req_aw_id), .req_aw_addr(req_aw_addr), .req_aw_valid(req_aw_valid), .req_aw_ready(req_aw_ready),
    .req_w_data(req_w_data), .req_w_strb(req_w_strb), .req_w_valid(req_w_valid), .req_w_ready(req_w_ready),
    .req_b_id(req_b_id), .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_id(axi_b_id), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready)
  );
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // requester BFMs: present queue heads, pop on handshake; also log downstream fires
  initial begin : drv
    bit hs_aw[2], hs_w[2];
    req_aw_valid = '0; req_w_valid = '0; req_aw_id = '0; req_aw_addr = '0; req_w_data = '0; req_w_strb = '0;
    forever begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        req_aw_valid[k] = awq[k].size() > 0;
        req_w_valid[k]  = wq[k].size() > 0;
        if (awq[k].size() > 0) begin req_aw_id[k] = awq[k][0].id; req_aw_addr[k] = awq[k][0].addr; end
        if (wq[k].size() > 0) begin req_w_data[k] = wq[k][0].d; req_w_strb[k] = wq[k][0].s; end
      end
      #3;
      for (int k = 0; k < 2; k++) begin
        hs_aw[k] = req_aw_valid[k] && req_aw_ready[k];
        hs_w[k]  = req_w_valid[k] && req_w_ready[k];
      end
      if (axi_aw_valid && axi_aw_ready) awlog.push_back(int'(axi_aw_id[4]));
      if (axi_w_valid && axi_w_ready) wlog.push_back(axi_w_data);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (hs_aw[k]) void'(awq[k].pop_front());
        if (hs_w[k]) void'(wq[k].pop_front());
      end
    end
  end
  // reference model: slots as flags, grant order as a queue of requester numbers
  initial begin : model
    int rr, g;
    int ordq[$];
    bit mav, mwv, awf, wfr, wf;
    logic gi, hd;
    logic [4:0] maid;
    logic [31:0] maddr;
    logic [127:0] mwd;
    logic [15:0] mws;
    logic [1:0] e_awr, e_wr, e_bv;
    rr = 0; mav = 0; mwv = 0; maid = '0; maddr = '0; mwd = '0; mws = '0;
    @(posedge clk);
    forever begin
      @(negedge clk); #2;
      awf = !mav || axi_aw_ready;
      wfr = !mwv || axi_w_ready;
      g = -1;
      if (!rst && awf && ordq.size() < 4)
        for (int i = 0; i < 2; i++) if (g < 0 && req_aw_valid[(rr + i) % 2]) g = (rr + i) % 2;
      gi = (g == 1);
      hd = (ordq.size() > 0) ? (ordq[0] == 1) : 1'b0;
      wf = !rst && wfr && ordq.size() > 0 && req_w_valid[hd];
      e_awr = (g < 0) ? 2'b00 : (gi ? 2'b10 : 2'b01);
      e_wr  = !wf ? 2'b00 : (hd ? 2'b10 : 2'b01);
      e_bv  = !axi_b_valid ? 2'b00 : (axi_b_id[4] ? 2'b10 : 2'b01);
      chk("m_aw_ready", req_aw_ready, e_awr);
      chk("m_w_ready", req_w_ready, e_wr);
      chk("m_aw_valid", axi_aw_valid, mav);
      if (mav) begin chk("m_aw_id", axi_aw_id, maid); chk("m_aw_addr", axi_aw_addr, maddr); end
      chk("m_w_valid", axi_w_valid, mwv);
      if (mwv) begin chk("m_w_data", axi_w_data, mwd); chk("m_w_strb", axi_w_strb, mws); end
      chk("m_b_valid", req_b_valid, e_bv);
      chk("m_b_ready", axi_b_ready, req_b_ready[axi_b_id[4]]);
      chk("m_b_id0", req_b_id[0], axi_b_id[3:0]);
      chk("m_b_id1", req_b_id[1], axi_b_id[3:0]);
      @(posedge clk);
      if (rst) begin
        rr = 0; mav = 0; mwv = 0; ordq.delete();
      end else begin
        if (wfr) mwv = wf;
        if (wf) begin mwd = req_w_data[hd]; mws = req_w_strb[hd]; void'(ordq.pop_front()); end
        if (awf) mav = (g >= 0);
        if (g >= 0) begin
          maid = {gi, req_aw_id[gi]}; maddr = req_aw_addr[gi];
          ordq.push_back(g); rr = (g + 1) % 2;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; axi_aw_ready = 1'b1; axi_w_ready = 1'b1;
    axi_b_valid = 1'b0; axi_b_id = '0; req_b_ready = 2'b11;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_aw_valid", axi_aw_valid, 1'b0);
    chk("rst_w_valid", axi_w_valid, 1'b0);
    chk("rst_aw_id", axi_aw_id, 5'h0);
    chk("rst_aw_addr", axi_aw_addr, 32'h0);
    @(negedge clk); rst = 1'b0;
    // single requester end to end
    @(negedge clk);
    awq[0].push_back('{4'h3, 32'h1000});
    wq[0].push_back('{{16{8'hA5}}, 16'hFFFF});
    #3; chk("t1_aw_ready", req_aw_ready, 2'b01); chk("t1_w_ready_early", req_w_ready, 2'b00);
    @(negedge clk); #3;
    chk("t1_aw_valid", axi_aw_valid, 1'b1); chk("t1_aw_id", axi_aw_id, 5'h03);
    chk("t1_aw_addr", axi_aw_addr, 32'h1000); chk("t1_w_ready", req_w_ready, 2'b01);
    @(negedge clk); #3;
    chk("t1_w_valid", axi_w_valid, 1'b1); chk("t1_w_data", axi_w_data, {16{8'hA5}});
    chk("t1_w_strb", axi_w_strb, 16'hFFFF);
    @(negedge clk); axi_b_valid = 1'b1; axi_b_id = 5'h03;
    #3; chk("t1_b_valid", req_b_valid, 2'b01); chk("t1_b_id", req_b_id[0], 4'h3); chk("t1_b_ready", axi_b_ready, 1'b1);
    @(negedge clk); axi_b_valid = 1'b0;
    // W before AW on requester 1
    @(negedge clk); wlog.delete();
    wq[1].push_back('{128'h77, 16'h00FF});
    repeat (5) begin #3; chk("wf_w_held", req_w_ready, 2'b00); @(negedge clk); end
    awq[1].push_back('{4'h9, 32'h2000});
    #3; chk("wf_aw_ready", req_aw_ready, 2'b10); chk("wf_w_still_held", req_w_ready, 2'b00);
    @(negedge clk); #3; chk("wf_w_ready", req_w_ready, 2'b10);
    @(negedge clk); #3; chk("wf_w_data", axi_w_data, 128'h77);
    repeat (3) @(negedge clk);
    chk("wf_w_count", wlog.size(), 1);
    // contention: requester 1 offers W first, but W order must follow AW order
    awlog.delete(); wlog.delete();
    awq[0].push_back('{4'h1, 32'h3000}); awq[0].push_back('{4'h2, 32'h3010});
    awq[1].push_back('{4'h4, 32'h4000}); awq[1].push_back('{4'h5, 32'h4010});
    wq[1].push_back('{128'h10, 16'h0001}); wq[1].push_back('{128'h11, 16'h0003});
    repeat (2) @(negedge clk);
    wq[0].push_back('{128'h00, 16'h0007}); wq[0].push_back('{128'h01, 16'h000F});
    repeat (12) @(negedge clk);
    chk("ct_aw_count", awlog.size(), 4);
    chk("ct_w_count", wlog.size(), 4);
    if (awlog.size() == 4) begin
      chk("ct_aw0", awlog[0], 0); chk("ct_aw1", awlog[1], 1);
      chk("ct_aw2", awlog[2], 0); chk("ct_aw3", awlog[3], 1);
    end
    if (wlog.size() == 4) begin
      chk("ct_w0", wlog[0], 128'h00); chk("ct_w1", wlog[1], 128'h10);
      chk("ct_w2", wlog[2], 128'h01); chk("ct_w3", wlog[3], 128'h11);
    end
    // backpressure: order FIFO fills at OrdDepth
    awlog.delete(); wlog.delete(); axi_w_ready = 1'b0;
    for (int i = 0; i < 5; i++) awq[0].push_back('{4'(i), 32'h5000 + 32'(i * 16)});
    repeat (8) @(negedge clk);
    #3; chk("bp_aw_count", awlog.size(), 4); chk("bp_aw_blocked", req_aw_ready, 2'b00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) wq[0].push_back('{128'hB0 + 128'(i), 16'hFFFF});
    #3; chk("bp_w_ready", req_w_ready, 2'b01);
    @(negedge clk); #3; chk("bp_aw_fifth", req_aw_ready, 2'b01);
    repeat (3) begin
      @(negedge clk); #3;
      chk("bp_w_stall_valid", axi_w_valid, 1'b1); chk("bp_w_stall_data", axi_w_data, 128'hB0);
    end
    @(negedge clk); axi_w_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp_aw_total", awlog.size(), 5); chk("bp_w_total", wlog.size(), 5);
    // B routing with requester-side backpressure
    axi_b_valid = 1'b1; axi_b_id = 5'h17; req_b_ready = 2'b01;
    repeat (3) begin
      #3; chk("b_ready_low", axi_b_ready, 1'b0); chk("b_valid_r1", req_b_valid, 2'b10);
      chk("b_id_r1", req_b_id[1], 4'h7);
      @(negedge clk);
    end
    req_b_ready = 2'b11;
    #3; chk("b_ready_high", axi_b_ready, 1'b1);
    @(negedge clk); axi_b_valid = 1'b0;
    // reset with traffic in flight
    axi_w_ready = 1'b0;
    for (int i = 0; i < 3; i++) awq[0].push_back('{4'h8, 32'h6000 + 32'(i * 16)});
    wq[0].push_back('{128'hC0, 16'hFFFF});
    repeat (5) @(negedge clk);
    #3; chk("mr_pre_aw_fifo_full_no", req_aw_ready, 2'b00); chk("mr_pre_w_valid", axi_w_valid, 1'b1);
    @(negedge clk); rst = 1'b1;
    awq[1].push_back('{4'h2, 32'h7000}); wq[0].push_back('{128'hC1, 16'hFFFF});
    #3; chk("mr_rst_aw_ready", req_aw_ready, 2'b00); chk("mr_rst_w_ready", req_w_ready, 2'b00);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin awq[k].delete(); wq[k].delete(); end
    #3; chk("mr_aw_valid", axi_aw_valid, 1'b0); chk("mr_w_valid", axi_w_valid, 1'b0);
    @(negedge clk);
    axi_w_ready = 1'b1;
    awq[0].push_back('{4'h5, 32'h8000}); awq[1].push_back('{4'h6, 32'h9000});
    wq[0].push_back('{128'hD0, 16'hFFFF}); wq[1].push_back('{128'hD1, 16'hFFFF});
    #3; chk("mr_first_grant", req_aw_ready, 2'b01); chk("mr_fifo_empty", req_w_ready, 2'b00);
    @(negedge clk); #3; chk("mr_aw_id", axi_aw_id, 5'h05);
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
